// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and the M-extension sequencer state type.
package riscv_pkg;

    localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] ALUSEL_MEXT = 2'b01;

    localparam logic [4:0] ALUSEL_MUL    = {F3_MUL,    ALUSEL_MEXT};
    localparam logic [4:0] ALUSEL_MULH   = {F3_MULH,   ALUSEL_MEXT};
    localparam logic [4:0] ALUSEL_MULHSU = {F3_MULHSU, ALUSEL_MEXT};
    localparam logic [4:0] ALUSEL_MULHU  = {F3_MULHU,  ALUSEL_MEXT};
    localparam logic [4:0] ALUSEL_DIV    = {F3_DIV,    ALUSEL_MEXT};
    localparam logic [4:0] ALUSEL_DIVU   = {F3_DIVU,   ALUSEL_MEXT};
    localparam logic [4:0] ALUSEL_REM    = {F3_REM,    ALUSEL_MEXT};
    localparam logic [4:0] ALUSEL_REMU   = {F3_REMU,   ALUSEL_MEXT};

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } mds_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or the restoring divider.
module muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opb,
    output logic [XLEN-1:0] acc_nxt_c,
    output logic [XLEN-1:0] lo_nxt_c
);

    logic [XLEN:0] sum;
    logic [XLEN:0] part_rem;
    logic [XLEN:0] divisor;

    // The partial remainder never exceeds twice the divisor, so it fits in XLEN+1 bits.
    always_comb begin
        sum       = {1'b0, acc};
        part_rem  = {acc, lo[XLEN-1]};
        divisor   = {1'b0, opb};
        acc_nxt_c = acc;
        lo_nxt_c  = lo;
        if (is_div) begin
            if (part_rem >= divisor) begin
                acc_nxt_c = XLEN'(part_rem - divisor);
                lo_nxt_c  = {lo[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt_c = part_rem[XLEN-1:0];
                lo_nxt_c  = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            if (lo[0]) begin
                sum = {1'b0, acc} + divisor;
            end
            acc_nxt_c = sum[XLEN:1];
            lo_nxt_c  = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M controller: sign prep, XLEN bit-serial iterations,
// sign fix-up and a single-cycle result strobe.
module muldiv_sequencer
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      alu_sel,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            reg_wen
);

    mds_state_t state, state_nxt;

    logic [2:0]        funct3_q;
    logic [XLEN-1:0]   op_a, op_b;
    logic [XLEN-1:0]   opb_abs;
    logic [XLEN-1:0]   acc, lo;
    logic [XLEN-1:0]   acc_nxt_c, lo_nxt_c;
    logic              sign_a, sign_b;
    logic [CNT_W-1:0]  cnt;

    logic              accept_c;
    logic              is_div;
    logic              signed_a, signed_b;
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              div_zero, div_ovf, fast_c;
    logic [XLEN-1:0]   fast_result;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

    assign accept_c = (state == IDLE) && start && (alu_sel[1:0] == ALUSEL_MEXT) && !flush;
    assign stall    = accept_c || (state == PREP) || (state == CALC) || (state == FIX);
    assign is_div   = funct3_q[2];

    // Operand signedness, absolute values and the divide fast paths.
    always_comb begin
        signed_a    = (funct3_q == F3_MULH) || (funct3_q == F3_MULHSU) ||
                      (funct3_q == F3_DIV)  || (funct3_q == F3_REM);
        signed_b    = (funct3_q == F3_MULH) || (funct3_q == F3_DIV) || (funct3_q == F3_REM);
        neg_a       = signed_a && op_a[XLEN-1];
        neg_b       = signed_b && op_b[XLEN-1];
        abs_a       = neg_a ? -op_a : op_a;
        abs_b       = neg_b ? -op_b : op_b;
        div_zero    = is_div && (op_b == '0);
        div_ovf     = ((funct3_q == F3_DIV) || (funct3_q == F3_REM)) &&
                      (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        fast_c      = div_zero || div_ovf;
        fast_result = op_a;
        if (div_zero) begin
            fast_result = funct3_q[1] ? op_a : '1;
        end else if (funct3_q[1]) begin
            fast_result = '0;
        end
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div    (is_div),
        .acc       (acc),
        .lo        (lo),
        .opb       (opb_abs),
        .acc_nxt_c (acc_nxt_c),
        .lo_nxt_c  (lo_nxt_c)
    );

    // Sign correction and word selection applied in FIX.
    always_comb begin
        prod       = {acc, lo};
        prod_fix   = (sign_a ^ sign_b) ? -prod : prod;
        quo_fix    = (sign_a ^ sign_b) ? -lo : lo;
        rem_fix    = sign_a ? -acc : acc;
        fix_result = rem_fix;
        case (funct3_q)
            F3_MUL:                       fix_result = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_result = quo_fix;
            default:                      fix_result = rem_fix;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept_c) state_nxt = PREP;
            PREP: begin
                if (flush)       state_nxt = IDLE;
                else if (fast_c) state_nxt = DONE;
                else             state_nxt = CALC;
            end
            CALC: begin
                if (flush)                              state_nxt = IDLE;
                else if (cnt == CNT_W'(XLEN - 1))       state_nxt = FIX;
            end
            FIX:  state_nxt = flush ? IDLE : DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and registered status strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            done    <= 1'b0;
            reg_wen <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            done    <= (state_nxt == DONE);
            reg_wen <= (state_nxt == DONE);
            busy    <= (state_nxt != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_q <= '0;
            op_a     <= '0;
            op_b     <= '0;
            opb_abs  <= '0;
            acc      <= '0;
            lo       <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            cnt      <= '0;
            result   <= '0;
        end else begin
            if (accept_c) begin
                funct3_q <= alu_sel[4:2];
                op_a     <= rs1_data;
                op_b     <= rs2_data;
            end
            case (state)
                PREP: begin
                    sign_a  <= neg_a;
                    sign_b  <= neg_b;
                    lo      <= abs_a;
                    opb_abs <= abs_b;
                    acc     <= '0;
                    cnt     <= '0;
                    if (!flush && fast_c) result <= fast_result;
                end
                CALC: begin
                    acc <= acc_nxt_c;
                    lo  <= lo_nxt_c;
                    cnt <= cnt + 1'b1;
                end
                FIX: if (!flush) result <= fix_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  alu_sel;
    logic [31:0] rs1_data, rs2_data;
    logic        flush;
    logic        stall, busy, done, reg_wen;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .alu_sel  (alu_sel),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .reg_wen  (reg_wen)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one op for a single cycle and observe until done (lat = -1 on timeout).
    task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int stalls, output logic [31:0] res,
                          output logic wen);
        lat = -1; stalls = 0; res = '0; wen = 1'b0;
        @(negedge clk);
        start = 1'b1; alu_sel = sel; rs1_data = a; rs2_data = b;
        @(posedge clk);
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (stall) stalls++;
            if (done) begin
                lat = n; res = result; wen = reg_wen;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({stall, busy, done, reg_wen} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {stall, busy, done, reg_wen});
        end
        checks++;
        if (result !== 32'h0) begin
            errors++;
            $display("FAIL reset_result: got %h expected 00000000", result);
        end
    endtask

    task automatic test_mul();
        int lat, st; logic [31:0] res; logic wen;
        run_op(ALUSEL_MUL, 32'd7, 32'hFFFFFFFD, lat, st, res, wen);
        checks++;
        if (lat !== 35) begin errors++; $display("FAIL mul_latency: got %0d expected 35", lat); end
        checks++;
        if (st !== 34) begin errors++; $display("FAIL mul_stall_cycles: got %0d expected 34", st); end
        checks++;
        if (res !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_result: got %h expected ffffffeb", res); end
        checks++;
        if (wen !== 1'b1) begin errors++; $display("FAIL mul_reg_wen: got %b expected 1", wen); end
    endtask

    task automatic test_mulh();
        int lat, st; logic [31:0] res; logic wen;
        logic [4:0]  sels [3] = '{ALUSEL_MULH, ALUSEL_MULHSU, ALUSEL_MULHU};
        logic [31:0] exps [3] = '{32'h00000000, 32'h80000000, 32'h7FFFFFFF};
        for (int i = 0; i < 3; i++) begin
            run_op(sels[i], 32'h80000000, 32'hFFFFFFFF, lat, st, res, wen);
            checks++;
            if (res !== exps[i] || lat !== 35) begin
                errors++;
                $display("FAIL mulh_variant%0d: got %h lat %0d expected %h lat 35", i, res, lat, exps[i]);
            end
        end
    endtask

    task automatic test_div();
        int lat, st; logic [31:0] res; logic wen;
        logic [4:0]  sels [4] = '{ALUSEL_DIV, ALUSEL_REM, ALUSEL_DIVU, ALUSEL_REMU};
        logic [31:0] as   [4] = '{32'hFFFFFFEC, 32'hFFFFFFEC, 32'd100, 32'd100};
        logic [31:0] bs   [4] = '{32'd6, 32'd6, 32'd7, 32'd7};
        logic [31:0] exps [4] = '{32'hFFFFFFFD, 32'hFFFFFFFE, 32'd14, 32'd2};
        for (int i = 0; i < 4; i++) begin
            run_op(sels[i], as[i], bs[i], lat, st, res, wen);
            checks++;
            if (res !== exps[i] || lat !== 35) begin
                errors++;
                $display("FAIL div_case%0d: got %h lat %0d expected %h lat 35", i, res, lat, exps[i]);
            end
        end
    endtask

    task automatic test_div_special();
        int lat, st; logic [31:0] res; logic wen;
        logic [4:0]  sels [4] = '{ALUSEL_DIVU, ALUSEL_REM, ALUSEL_DIV, ALUSEL_REM};
        logic [31:0] as   [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs   [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exps [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        for (int i = 0; i < 4; i++) begin
            run_op(sels[i], as[i], bs[i], lat, st, res, wen);
            checks++;
            if (res !== exps[i] || lat !== 2) begin
                errors++;
                $display("FAIL special_case%0d: got %h lat %0d expected %h lat 2", i, res, lat, exps[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat; int st; logic [31:0] res; logic wen;
        lat = -1;
        @(negedge clk);
        start = 1'b1; alu_sel = ALUSEL_MUL; rs1_data = 32'd7; rs2_data = 32'hFFFFFFFD;
        @(posedge clk);
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            // A different MUL offered mid-operation must be ignored.
            start = (n >= 5 && n <= 7);
            if (start) begin rs1_data = 32'd3; rs2_data = 32'd3; end
            if (done) begin
                lat = n; res = result;
                checks++;
                if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_done: got %b expected 0", stall); end
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (lat !== 35 || res !== 32'hFFFFFFEB) begin
            errors++;
            $display("FAIL b2b_first: got %h lat %0d expected ffffffeb lat 35", res, lat);
        end
        run_op(ALUSEL_MUL, 32'd7, 32'hFFFFFFFD, lat, st, res, wen);
        checks++;
        if (lat !== 35 || res !== 32'hFFFFFFEB) begin
            errors++;
            $display("FAIL b2b_second: got %h lat %0d expected ffffffeb lat 35", res, lat);
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        @(negedge clk);
        start = 1'b1; alu_sel = ALUSEL_DIVU; rs1_data = 32'd100; rs2_data = 32'd7;
        @(posedge clk);
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) seen++;
        end
        // Cycle 11 after accept is the tenth CALC cycle.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if ({busy, stall, done} !== 3'b000) begin
            errors++;
            $display("FAIL flush_idle: got busy/stall/done %b expected 000", {busy, stall, done});
        end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL flush_no_done: got %0d done pulses expected 0", seen); end
        checks++;
        if (result !== 32'hFFFFFFEB) begin errors++; $display("FAIL flush_result_hold: got %h expected ffffffeb", result); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        @(negedge clk);
        start = 1'b1; alu_sel = ALUSEL_MUL; rs1_data = 32'd9; rs2_data = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({stall, busy, done, reg_wen, result} !== 36'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %b %b %b %b %h expected all zero", stall, busy, done, reg_wen, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d done pulses expected 0", seen); end
    endtask

    task automatic test_non_m();
        @(negedge clk);
        start = 1'b1; alu_sel = 5'b00000; rs1_data = 32'd1; rs2_data = 32'd2;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL nonm_stall: got %b expected 0", stall); end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL nonm_busy: got %b expected 0", busy); end
    endtask

    task automatic test_flush_start();
        @(negedge clk);
        start = 1'b1; flush = 1'b1; alu_sel = ALUSEL_DIV; rs1_data = 32'd8; rs2_data = 32'd2;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL flushstart_stall: got %b expected 0", stall); end
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flushstart_busy: got %b expected 0", busy); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        alu_sel = '0; rs1_data = '0; rs2_data = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_mul();
        test_mulh();
        test_div();
        test_div_special();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_non_m();
        test_flush_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
